// File: rtl/chess_pkg.sv
// Shared constants for the move-generation datapath: collector FSM states and
// the piece/colour encodings used by the column units.
package chess_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        FINISH  = 2'd3
    } mc_state_e;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] KNIGHT = 3'd2;
    localparam logic [2:0] BISHOP = 3'd3;
    localparam logic [2:0] ROOK   = 3'd4;
    localparam logic [2:0] QUEEN  = 3'd5;
    localparam logic [2:0] KING   = 3'd6;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

endpackage

// File: rtl/move_fifo.sv
// Output buffer of the move collector: a strict FIFO of DEPTH entries.
// Push and pop may happen in the same cycle even when full; the head entry is
// presented combinationally and reads as zero while the buffer is empty.
module move_fifo #(
    parameter int MW    = 160,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [MW-1:0]            push_data,
    input  logic                     pop,
    output logic [MW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [MW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    // Accept handshakes and compute pointer / occupancy updates.
    always_comb begin
        pop_ok_s  = pop && (count_q != (AW+1)'(0));
        push_ok_s = push && ((count_q != FULL_CNT) || pop_ok_s);
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty    = (count_q == (AW+1)'(0));
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/move_collector.sv
// Merges the move FIFOs of NCOL column units into one output stream.
// A round-robin arbiter reads at most one column per cycle; the read data is
// captured the following cycle and pushed into move_fifo. A column just read is
// skipped for one cycle because its empty flag lags the read by a cycle.
module move_collector
    import chess_pkg::*;
#(
    parameter int NCOL  = 8,
    parameter int MW    = 160,
    parameter int DEPTH = 16,
    parameter int CW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    input  logic [NCOL-1:0]      col_done,
    input  logic [NCOL-1:0]      col_empty,
    input  logic [NCOL*MW-1:0]   col_data,
    output logic [NCOL-1:0]      col_rden,
    output logic [MW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        move_count,
    output logic                 done,
    output logic                 overflow
);
    localparam int IW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    mc_state_e       state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   last_idx_q, last_idx_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   move_count_q, move_count_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NCOL-1:0] excl_s, elig_s, col_rden_s;
    logic            gnt_valid_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            space_ok_s;
    logic            round_done_s;
    int              cand_s;

    logic            fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [AW:0]     fifo_count_s;
    logic [MW-1:0]   fifo_rdata_s, cap_data_s;

    // Round-robin arbiter: first eligible column at or after rr_ptr_q.
    always_comb begin
        excl_s = '0;
        if (inflight_q) begin
            excl_s[last_idx_q] = 1'b1;
        end else begin
            excl_s = '0;
        end
        elig_s      = ~col_empty & ~excl_s;
        space_ok_s  = ((32'(fifo_count_s) + 32'(inflight_q)) < 32'(DEPTH)) && !fifo_full_s;
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = 0;
        if ((state_q == COLLECT) && space_ok_s) begin
            for (int k = 0; k < NCOL; k++) begin
                cand_s = int'(rr_ptr_q) + k;
                if (cand_s >= NCOL) begin
                    cand_s = cand_s - NCOL;
                end else begin
                    cand_s = cand_s;
                end
                if (!gnt_valid_s && elig_s[cand_s]) begin
                    gnt_valid_s = 1'b1;
                    gnt_idx_s   = IW'(cand_s);
                end else begin
                    gnt_valid_s = gnt_valid_s;
                end
            end
        end else begin
            gnt_valid_s = 1'b0;
        end
    end

    assign round_done_s = (&col_done) && (&col_empty) && !inflight_q;

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? COLLECT : IDLE;
            COLLECT: state_d = round_done_s ? DRAIN : COLLECT;
            DRAIN:   state_d = fifo_empty_s ? FINISH : DRAIN;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: read strobe for the granted column, next busy/done flags.
    always_comb begin
        col_rden_s = '0;
        if (gnt_valid_s) begin
            col_rden_s[gnt_idx_s] = 1'b1;
        end else begin
            col_rden_s = '0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // Arbiter bookkeeping and the saturating move counter.
    always_comb begin
        inflight_d = gnt_valid_s;
        if (gnt_valid_s) begin
            last_idx_d = gnt_idx_s;
            rr_ptr_d   = (gnt_idx_s == IW'(NCOL-1)) ? '0 : (gnt_idx_s + IW'(1));
        end else begin
            last_idx_d = last_idx_q;
            rr_ptr_d   = rr_ptr_q;
        end
        move_count_d = move_count_q;
        overflow_d   = overflow_q;
        if ((state_q == IDLE) && start) begin
            move_count_d = '0;
            overflow_d   = 1'b0;
        end else if (fifo_push_s) begin
            if (move_count_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                move_count_d = move_count_q + CW'(1);
            end
        end else begin
            move_count_d = move_count_q;
        end
    end

    // State, arbiter and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            last_idx_q   <= '0;
            inflight_q   <= 1'b0;
            move_count_q <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            last_idx_q   <= last_idx_d;
            inflight_q   <= inflight_d;
            move_count_q <= move_count_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cap_data_s  = col_data[int'(last_idx_q)*MW +: MW];
    assign fifo_push_s = inflight_q;
    assign fifo_pop_s  = !fifo_empty_s && out_ready;

    move_fifo #(
        .MW    (MW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push_s),
        .push_data (cap_data_s),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign col_rden   = col_rden_s;
    assign out_valid  = !fifo_empty_s;
    assign out_data   = fifo_rdata_s;
    assign busy       = busy_q;
    assign done       = done_q;
    assign move_count = move_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: behavioural column FIFOs feed the DUT,
// outputs are compared against hand-computed values. A second instance with a
// 3-bit move counter shares all inputs to exercise counter saturation.
module tb_move_collector;
    localparam int NCOL  = 8;
    localparam int MW    = 160;
    localparam int DEPTH = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                out_ready = 1'b1;
    logic [NCOL-1:0]     col_done = '1;
    logic [NCOL-1:0]     col_empty = '1;
    logic [NCOL*MW-1:0]  col_data = '0;

    logic                busy, done, overflow, out_valid;
    logic [NCOL-1:0]     col_rden;
    logic [MW-1:0]       out_data;
    logic [9:0]          move_count;

    logic                s_busy, s_done, s_overflow, s_out_valid;
    logic [NCOL-1:0]     s_col_rden;
    logic [MW-1:0]       s_out_data;
    logic [2:0]          s_move_count;

    int checks = 0;
    int errors = 0;

    int              col_total [NCOL];
    int              col_rd    [NCOL];
    logic [MW-1:0]   col_reg   [NCOL];
    logic [MW-1:0]   rx [$];
    logic [NCOL-1:0] prev_rd;
    logic [MW-1:0]   stall_data;
    logic            stall_hold;
    int done_cnt, valid_seen, multi_rd, b2b, rd_cnt, unstable, bad_rd;

    always #5 clk = ~clk;

    move_collector #(.NCOL(NCOL), .MW(MW), .DEPTH(DEPTH), .CW(10)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .col_done(col_done), .col_empty(col_empty), .col_data(col_data),
        .col_rden(col_rden), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .move_count(move_count), .done(done),
        .overflow(overflow)
    );

    move_collector #(.NCOL(NCOL), .MW(MW), .DEPTH(DEPTH), .CW(3)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .busy(s_busy),
        .col_done(col_done), .col_empty(col_empty), .col_data(col_data),
        .col_rden(s_col_rden), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .move_count(s_move_count), .done(s_done),
        .overflow(s_overflow)
    );

    function automatic logic [MW-1:0] mk(int c, int s);
        logic [MW-1:0] v;
        v = '0;
        v[MW-1:MW-8] = 8'hC3;
        v[31:24]     = 8'h5A;
        v[23:16]     = 8'(c);
        v[15:0]      = 16'(s);
        return v;
    endfunction

    task automatic chk(string tag, logic [MW-1:0] obs, logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_cols();
        for (int i = 0; i < NCOL; i++) begin
            col_empty[i]           = (col_rd[i] >= col_total[i]);
            col_data[i*MW +: MW]   = col_reg[i];
        end
    endtask

    task automatic clear_cols();
        for (int i = 0; i < NCOL; i++) begin
            col_total[i] = 0;
            col_rd[i]    = 0;
            col_reg[i]   = '0;
        end
        refresh_cols();
    endtask

    task automatic clr_stats();
        rx.delete();
        prev_rd = '0; stall_hold = 1'b0; stall_data = '0;
        done_cnt = 0; valid_seen = 0; multi_rd = 0; b2b = 0;
        rd_cnt = 0; unstable = 0; bad_rd = 0;
    endtask

    // One clock: sample outputs at negedge, advance column models after posedge.
    task automatic tick();
        logic [NCOL-1:0] rd;
        @(negedge clk);
        rd = col_rden;
        if (out_valid && out_ready) rx.push_back(out_data);
        if (done) done_cnt++;
        if (out_valid) valid_seen++;
        if (!$onehot0(rd)) multi_rd++;
        if ((rd & prev_rd) != '0) b2b++;
        if (rd != '0) rd_cnt++;
        if (out_valid && !out_ready) begin
            if (stall_hold && (out_data !== stall_data)) unstable++;
            stall_hold = 1'b1;
            stall_data = out_data;
        end else begin
            stall_hold = 1'b0;
        end
        prev_rd = rd;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCOL; i++) begin
            if (rd[i]) begin
                if (col_rd[i] < col_total[i]) begin
                    col_reg[i] = mk(i, col_rd[i]);
                    col_rd[i]++;
                end else begin
                    bad_rd++;
                end
            end
        end
        refresh_cols();
    endtask

    task automatic start_round();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    initial begin
        int n;
        int cols4 [4];
        clear_cols();
        clr_stats();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", MW'(busy), MW'(0));
        chk("rst_done", MW'(done), MW'(0));
        chk("rst_valid", MW'(out_valid), MW'(0));
        chk("rst_rden", MW'(col_rden), MW'(0));
        chk("rst_count", MW'(move_count), MW'(0));
        chk("rst_ovf", MW'(overflow), MW'(0));
        chk("rst_data", out_data, MW'(0));
        @(negedge clk);
        reset = 1'b1;

        // Two columns with two entries each: interleaved col3,col5,col3,col5
        clear_cols(); clr_stats();
        col_total[3] = 2; col_total[5] = 2;
        refresh_cols();
        start_round();
        chk("a_busy", MW'(busy), MW'(1));
        wait_done(100);
        chk("a_done_pulses", MW'(done_cnt), MW'(1));
        chk("a_rx_len", MW'(rx.size()), MW'(4));
        if (rx.size() == 4) begin
            chk("a_rx0", rx[0], mk(3, 0));
            chk("a_rx1", rx[1], mk(5, 0));
            chk("a_rx2", rx[2], mk(3, 1));
            chk("a_rx3", rx[3], mk(5, 1));
        end
        chk("a_count", MW'(move_count), MW'(4));
        chk("a_busy_end", MW'(busy), MW'(0));
        chk("a_multi_rd", MW'(multi_rd), MW'(0));

        // Empty round: done on the third sample after start, nothing out
        clear_cols(); clr_stats();
        start_round();
        repeat (3) tick();
        chk("b_done_by4", MW'(done_cnt), MW'(1));
        tick();
        chk("b_done_once", MW'(done_cnt), MW'(1));
        chk("b_count", MW'(move_count), MW'(0));
        chk("b_valid", MW'(valid_seen), MW'(0));

        // Back-pressure: 40 pending, buffer holds 16, order col0,1,2,4 repeating
        clear_cols(); clr_stats();
        cols4[0] = 0; cols4[1] = 1; cols4[2] = 2; cols4[3] = 4;
        for (int j = 0; j < 4; j++) col_total[cols4[j]] = 10;
        refresh_cols();
        out_ready = 1'b0;
        start_round();
        repeat (60) tick();
        chk("c_reads", MW'(rd_cnt), MW'(16));
        chk("c_rden_low", MW'(col_rden), MW'(0));
        chk("c_valid", MW'(out_valid), MW'(1));
        chk("c_head", out_data, mk(0, 0));
        chk("c_stable", MW'(unstable), MW'(0));
        chk("c_count", MW'(move_count), MW'(16));
        chk("c_sat_count", MW'(s_move_count), MW'(7));
        chk("c_sat_ovf", MW'(s_overflow), MW'(1));
        out_ready = 1'b1;
        wait_done(300);
        chk("c_done_pulses", MW'(done_cnt), MW'(1));
        chk("c_rx_len", MW'(rx.size()), MW'(40));
        if (rx.size() == 40) begin
            for (int k = 0; k < 10; k++) begin
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("c_rx%0d", k*4+j), rx[k*4+j], mk(cols4[j], k));
                end
            end
        end
        chk("c_count_end", MW'(move_count), MW'(40));
        chk("c_bad_rd", MW'(bad_rd), MW'(0));

        // Single column with 9 entries: every other cycle, 3-bit counter saturates
        clear_cols(); clr_stats();
        col_total[2] = 9;
        refresh_cols();
        start_round();
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("d_rx_at_done", MW'(rx.size()), MW'(9));
        chk("d_b2b", MW'(b2b), MW'(0));
        chk("d_reads", MW'(rd_cnt), MW'(9));
        chk("d_count", MW'(move_count), MW'(9));
        chk("d_ovf", MW'(overflow), MW'(0));
        chk("d_sat_count", MW'(s_move_count), MW'(7));
        chk("d_sat_ovf", MW'(s_overflow), MW'(1));

        // Not all columns done: round holds until col_done completes; start clears saturation
        clear_cols(); clr_stats();
        col_done = 8'hBF;
        start_round();
        chk("e_sat_clr_count", MW'(s_move_count), MW'(0));
        chk("e_sat_clr_ovf", MW'(s_overflow), MW'(0));
        repeat (10) tick();
        chk("e_hold_busy", MW'(busy), MW'(1));
        chk("e_hold_done", MW'(done_cnt), MW'(0));
        col_done = 8'hFF;
        repeat (4) tick();
        chk("e_done", MW'(done_cnt), MW'(1));

        // Reset mid-collection with 5 buffered
        clear_cols(); clr_stats();
        col_total[0] = 10; col_total[1] = 10;
        refresh_cols();
        out_ready = 1'b0;
        start_round();
        n = 0;
        while (move_count != 10'd5 && n < 40) begin
            tick();
            n++;
        end
        chk("f_count5", MW'(move_count), MW'(5));
        reset = 1'b0;
        #1;
        chk("f_rst_valid", MW'(out_valid), MW'(0));
        chk("f_rst_busy", MW'(busy), MW'(0));
        chk("f_rst_rden", MW'(col_rden), MW'(0));
        chk("f_rst_count", MW'(move_count), MW'(0));
        chk("f_rst_data", out_data, MW'(0));
        @(negedge clk);
        reset = 1'b1;
        clr_stats();
        out_ready = 1'b1;
        repeat (10) tick();
        chk("f_no_done", MW'(done_cnt), MW'(0));
        chk("f_no_valid", MW'(valid_seen), MW'(0));
        chk("f_count_after", MW'(move_count), MW'(0));
        chk("f_busy_after", MW'(busy), MW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
